// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//
// Shares the main memory bus (general RAM, CGA text RAM, BIOS ROM) between
// the CPU core and a DMA requester. A four-state sequencer (IDLE, GRANT,
// WAIT, ACK) serialises accesses. The latched address is decoded into
// region write strobes and a read-data select. Each access is completed
// with a one-cycle acknowledge pulse to its owner.
//
// Optional feature:
//   MEMARB_ROUNDROBIN_EN  defined     -> ties alternate between the ports
//                                        (first tie after reset goes to DMA)
//                         undefined   -> fixed priority, DMA wins every tie
//
// Ports:
//   clock_i                   system clock, rising edge
//   reset_i                   asynchronous, active-high reset
//   cpu_req_i / dma_req_i     level request, held until the matching ack
//   cpu_we_i / dma_we_i       1 = write, 0 = read
//   cpu_address_i / dma_...   byte address (AW bits)
//   cpu_data_i / dma_data_i   write data (DW bits)
//   cpu_q_o / dma_q_o         read data, valid in the ack cycle, then held
//   cpu_ack_o / dma_ack_o     one-cycle completion pulse
//   address_o / data_o        shared memory address and write data
//   we_memory_o               write strobe for 00000-3FFFF
//   we_cgamem_o               write strobe for B8000-B9FFF
//   q_memory_i / q_cgamem_i / q_bios_i  registered memory read outputs
//   grant_o                   current owner: 01 = CPU, 10 = DMA, 00 = idle

module mem_arbiter #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 8
) (
    input  logic          clock_i,
    input  logic          reset_i,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_address_i,
    input  logic [DW-1:0] cpu_data_i,
    output logic [DW-1:0] cpu_q_o,
    output logic          cpu_ack_o,

    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_address_i,
    input  logic [DW-1:0] dma_data_i,
    output logic [DW-1:0] dma_q_o,
    output logic          dma_ack_o,

    output logic [AW-1:0] address_o,
    output logic [DW-1:0] data_o,
    output logic          we_memory_o,
    output logic          we_cgamem_o,
    input  logic [DW-1:0] q_memory_i,
    input  logic [DW-1:0] q_cgamem_i,
    input  logic [DW-1:0] q_bios_i,

    output logic [1:0]    grant_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StAck   = 2'd3;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantCpu  = 2'b01;
    localparam logic [1:0] GrantDma  = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] cpu_q_q, cpu_q_d;
    logic [DW-1:0] dma_q_q, dma_q_d;

    logic pick_cpu, pick_dma;
    logic is_mem, is_cga, is_bios;
    logic [DW-1:0] rdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef MEMARB_ROUNDROBIN_EN
    // High means DMA wins the next tie. Reset favours DMA.
    logic prio_dma_q, prio_dma_d;

    always_comb begin
        pick_cpu = 1'b0;
        pick_dma = 1'b0;
        if (cpu_req_i && dma_req_i) begin
            if (prio_dma_q) begin
                pick_dma = 1'b1;
            end else begin
                pick_cpu = 1'b1;
            end
        end else if (cpu_req_i) begin
            pick_cpu = 1'b1;
        end else if (dma_req_i) begin
            pick_dma = 1'b1;
        end
    end

    // The pointer follows every grant, contended or not: the port that just
    // won loses the next tie.
    always_comb begin
        prio_dma_d = prio_dma_q;
        if (state_q == StIdle && (pick_cpu || pick_dma)) begin
            prio_dma_d = pick_cpu;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prio_dma_q <= 1'b1;
        end else begin
            prio_dma_q <= prio_dma_d;
        end
    end
`else
    // Fixed priority: DMA always wins a tie.
    always_comb begin
        pick_dma = dma_req_i;
        pick_cpu = cpu_req_i && !dma_req_i;
    end
`endif

    // ------------------------------------------------------------------
    // Address decode on the latched address
    // ------------------------------------------------------------------
    // Only the top bits take part; lower bits pass straight to the memory.
    always_comb begin
        is_mem  = (addr_q[AW-1 -: 2] == 2'b00);
        is_cga  = (addr_q[AW-1 -: 7] == 7'b1011100);
        is_bios = (addr_q[AW-1 -: 7] == 7'b1111000);
    end

    // Unmapped reads float high, like an undriven bus.
    always_comb begin
        if (is_mem) begin
            rdata = q_memory_i;
        end else if (is_cga) begin
            rdata = q_cgamem_i;
        end else if (is_bios) begin
            rdata = q_bios_i;
        end else begin
            rdata = {DW{1'b1}};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cpu_q_d = cpu_q_q;
        dma_q_d = dma_q_q;

        case (state_q)
            StIdle: begin
                if (pick_cpu) begin
                    grant_d = GrantCpu;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_address_i;
                    data_d  = cpu_data_i;
                    state_d = StGrant;
                end else if (pick_dma) begin
                    grant_d = GrantDma;
                    we_d    = dma_we_i;
                    addr_d  = dma_address_i;
                    data_d  = dma_data_i;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                state_d = StWait;
            end
            StWait: begin
                // Memory output is valid now; capture it on the edge into ACK
                // so the owner's q is already valid while its ack is high.
                if (grant_q == GrantCpu) begin
                    cpu_q_d = rdata;
                end else begin
                    dma_q_d = rdata;
                end
                state_d = StAck;
            end
            StAck: begin
                grant_d = GrantNone;
                state_d = StIdle;
            end
            default: begin
                grant_d = GrantNone;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            grant_q <= GrantNone;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cpu_q_q <= {DW{1'b1}};
            dma_q_q <= {DW{1'b1}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cpu_q_q <= cpu_q_d;
            dma_q_q <= dma_q_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic strobe_en;

    always_comb begin
        // Strobes exist only in GRANT, so each write hits memory exactly once.
        strobe_en   = (state_q == StGrant) && we_q;
        we_memory_o = strobe_en && is_mem;
        we_cgamem_o = strobe_en && is_cga;

        cpu_ack_o   = (state_q == StAck) && (grant_q == GrantCpu);
        dma_ack_o   = (state_q == StAck) && (grant_q == GrantDma);

        address_o   = addr_q;
        data_o      = data_q;
        cpu_q_o     = cpu_q_q;
        dma_q_o     = dma_q_q;
        grant_o     = grant_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter: reset values, tie arbitration, CPU read and
// write, unmapped/BIOS accesses, early req drop and reset mid-transaction.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [19:0] cpu_address, dma_address, address;
    logic [7:0]  cpu_data, dma_data, cpu_q, dma_q, data;
    logic        cpu_ack, dma_ack, we_memory, we_cgamem;
    logic [7:0]  q_memory, q_cgamem, q_bios;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_g [4];
    logic [1:0] exp_a [4];

    always #5 clock = ~clock;

    mem_arbiter #(.AW(20), .DW(8)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_address_i (cpu_address),
        .cpu_data_i    (cpu_data),
        .cpu_q_o       (cpu_q),
        .cpu_ack_o     (cpu_ack),
        .dma_req_i     (dma_req),
        .dma_we_i      (dma_we),
        .dma_address_i (dma_address),
        .dma_data_i    (dma_data),
        .dma_q_o       (dma_q),
        .dma_ack_o     (dma_ack),
        .address_o     (address),
        .data_o        (data),
        .we_memory_o   (we_memory),
        .we_cgamem_o   (we_cgamem),
        .q_memory_i    (q_memory),
        .q_cgamem_i    (q_cgamem),
        .q_bios_i      (q_bios),
        .grant_o       (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
`ifdef MEMARB_ROUNDROBIN_EN
        exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`else
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
`endif
        // {cpu_ack, dma_ack}: DMA grant -> 01, CPU grant -> 10
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = (exp_g[i] == 2'b10) ? 2'b01 : 2'b10;
        end

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_address = '0; cpu_data = '0;
        dma_req = 0; dma_we = 0; dma_address = '0; dma_data = '0;
        q_memory = 8'h5A; q_cgamem = 8'hC3; q_bios = 8'hEA;

        // Reset values
        step(2);
        chk("rst_grant", grant, 2'b00);
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_dma_ack", dma_ack, 1'b0);
        chk("rst_cpu_q", cpu_q, 8'hFF);
        chk("rst_dma_q", dma_q, 8'hFF);
        chk("rst_address", address, 20'h0);
        chk("rst_data", data, 8'h0);
        chk("rst_we_memory", we_memory, 1'b0);
        chk("rst_we_cgamem", we_cgamem, 1'b0);
        reset = 1'b0;
        step(1);

        // Both ports request continuously
        cpu_req = 1; cpu_we = 0; cpu_address = 20'h00030;
        dma_req = 1; dma_we = 0; dma_address = 20'hB8010;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("tie_grant", grant, exp_g[k]);
            step(2);
            chk("tie_ack", {cpu_ack, dma_ack}, exp_a[k]);
            if (k == 0) chk("tie_dma_q", dma_q, 8'hC3);
            if (k == 3) begin cpu_req = 0; dma_req = 0; end
            step(1);
        end
        step(1);
        chk("tie_end_grant", grant, 2'b00);
        chk("tie_end_ack", {cpu_ack, dma_ack}, 2'b00);

        // CPU read of 00010
        cpu_req = 1; cpu_we = 0; cpu_address = 20'h00010;
        step(1);
        chk("rd_grant_g", grant, 2'b01);
        chk("rd_address", address, 20'h00010);
        chk("rd_no_wem", we_memory, 1'b0);
        chk("rd_no_wec", we_cgamem, 1'b0);
        chk("rd_ack_early", cpu_ack, 1'b0);
        step(1);
        chk("rd_grant_w", grant, 2'b01);
        chk("rd_ack_wait", cpu_ack, 1'b0);
        step(1);
        chk("rd_ack", cpu_ack, 1'b1);
        chk("rd_q", cpu_q, 8'h5A);
        chk("rd_grant_a", grant, 2'b01);
        chk("rd_dma_ack", dma_ack, 1'b0);
        cpu_req = 0;
        step(1);
        chk("rd_ack_off", cpu_ack, 1'b0);
        chk("rd_grant_idle", grant, 2'b00);
        step(1);
        chk("rd_no_repeat", grant, 2'b00);

        // CPU write of 41 to B8002
        cpu_req = 1; cpu_we = 1; cpu_address = 20'hB8002; cpu_data = 8'h41;
        step(1);
        chk("wr_we_cgamem", we_cgamem, 1'b1);
        chk("wr_we_memory", we_memory, 1'b0);
        chk("wr_address", address, 20'hB8002);
        chk("wr_data", data, 8'h41);
        step(1);
        chk("wr_cga_off", we_cgamem, 1'b0);
        chk("wr_mem_off", we_memory, 1'b0);
        step(1);
        chk("wr_ack", cpu_ack, 1'b1);
        chk("wr_cga_ack", we_cgamem, 1'b0);
        cpu_req = 0; cpu_we = 0;
        step(1);
        chk("wr_ack_off", cpu_ack, 1'b0);

        // CPU drops req during GRANT; inputs changed mid-transaction
        q_memory = 8'h77;
        cpu_req = 1; cpu_address = 20'h00020;
        step(1);
        chk("drop_grant", grant, 2'b01);
        cpu_req = 0; cpu_address = 20'h50000;
        step(1);
        chk("drop_frozen_addr", address, 20'h00020);
        step(1);
        chk("drop_ack", cpu_ack, 1'b1);
        chk("drop_q", cpu_q, 8'h77);
        step(1);
        chk("drop_ack_off", cpu_ack, 1'b0);
        step(1);
        chk("drop_no_second", grant, 2'b00);

        // Unmapped read of 50000
        cpu_req = 1; cpu_address = 20'h50000;
        step(3);
        chk("unm_ack", cpu_ack, 1'b1);
        chk("unm_q", cpu_q, 8'hFF);
        cpu_req = 0;
        step(1);

        // Write to BIOS: no strobe, still acked
        cpu_req = 1; cpu_we = 1; cpu_address = 20'hF0000; cpu_data = 8'h12;
        step(1);
        chk("bios_wr_grant", grant, 2'b01);
        chk("bios_wr_strobes", {we_memory, we_cgamem}, 2'b00);
        step(2);
        chk("bios_wr_ack", cpu_ack, 1'b1);
        cpu_req = 0; cpu_we = 0;
        step(1);

        // DMA read of BIOS
        dma_req = 1; dma_we = 0; dma_address = 20'hF1234;
        step(1);
        chk("dma_bios_grant", grant, 2'b10);
        step(2);
        chk("dma_bios_ack", dma_ack, 1'b1);
        chk("dma_bios_q", dma_q, 8'hEA);
        chk("dma_bios_cpu_ack", cpu_ack, 1'b0);
        dma_req = 0;
        step(1);

        // DMA write, reset raised during WAIT
        dma_req = 1; dma_we = 1; dma_address = 20'h00100; dma_data = 8'h99;
        step(1);
        chk("rw_we_memory", we_memory, 1'b1);
        chk("rw_grant", grant, 2'b10);
        chk("rw_address", address, 20'h00100);
        chk("rw_data", data, 8'h99);
        step(1);
        chk("rw_wait_grant", grant, 2'b10);
        chk("rw_wait_we", we_memory, 1'b0);
        reset = 1; dma_req = 0; dma_we = 0;
        #1;
        chk("rw_rst_grant", grant, 2'b00);
        chk("rw_rst_address", address, 20'h0);
        chk("rw_rst_data", data, 8'h0);
        chk("rw_rst_we", we_memory, 1'b0);
        chk("rw_rst_dma_q", dma_q, 8'hFF);
        chk("rw_rst_cpu_q", cpu_q, 8'hFF);
        chk("rw_rst_dma_ack", dma_ack, 1'b0);
        step(1);
        chk("rw_no_ack_a", dma_ack, 1'b0);
        reset = 0;
        step(1);
        chk("rw_no_ack_b", dma_ack, 1'b0);
        chk("rw_idle_grant", grant, 2'b00);
        // A fresh request is granted after one edge only if the FSM is in IDLE
        cpu_req = 1; cpu_address = 20'h00010;
        step(1);
        chk("rw_post_grant", grant, 2'b01);
        step(2);
        chk("rw_post_ack", cpu_ack, 1'b1);
        chk("rw_post_q", cpu_q, 8'h77);
        cpu_req = 0;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
